instruction_queue: RTL and testbench

INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

---
 rtl/instruction_queue.sv | 64 ++++++
 tb/tb_instruction_queue.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_queue.sv
// Instruction prefetch queue: DEPTH-entry circular FIFO with flush, sticky overflow
// and a zeroed output word whenever the queue is empty.
module instruction_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             ir_load,
  input  logic [WIDTH-1:0] in_value,
  output logic             load_ready,
  input  logic             ir_advance,
  output logic [WIDTH-1:0] out_value,
  output logic             out_valid,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign load_ready = (count < CW'(DEPTH));
  assign push       = ir_load && load_ready && !flush;
  assign pop        = ir_advance && (count != '0) && !flush;
  assign out_valid  = (count != '0);
  // Gate the head word so a drained or flushed queue never exposes stale storage.
  assign out_value  = out_valid ? mem[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; count alone is enough to hide old entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (ir_load && !load_ready) overflow <= 1'b1;
    end
  end

  // NOTE: storage has no reset; the zeroed count already makes it unobservable,
  // and leaving it out lets the array map onto plain RAM/flops without reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_value;
  end

endmodule

// File: tb/tb_instruction_queue.sv
// Directed self-checking bench for instruction_queue (WIDTH=16, DEPTH=4).
module tb_instruction_queue;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             ir_load = 1'b0;
  logic [WIDTH-1:0] in_value = '0;
  logic             load_ready;
  logic             ir_advance = 1'b0;
  logic [WIDTH-1:0] out_value;
  logic             out_valid;
  logic [CW-1:0]    count;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  instruction_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .ir_load    (ir_load),
    .in_value   (in_value),
    .load_ready (load_ready),
    .ir_advance (ir_advance),
    .out_value  (out_value),
    .out_valid  (out_valid),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    ir_load  = 1'b1;
    in_value = w;
    step();
    ir_load  = 1'b0;
  endtask

  task automatic pop_word();
    ir_advance = 1'b1;
    step();
    ir_advance = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] exp_q [$];

    // Reset values while rst_n is low, before any edge.
    #3;
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_value", 32'(out_value), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd1);
    #9 rst_n = 1'b1;

    // Basic load with one-cycle latency, then consume.
    push_word(16'hFDFD);
    check("load_lat_value", 32'(out_value), 32'hFDFD);
    step();
    check("load_value", 32'(out_value), 32'hFDFD);
    check("load_valid", 32'(out_valid), 32'd1);
    check("load_count", 32'(count), 32'd1);
    pop_word();
    check("adv_valid", 32'(out_valid), 32'd0);
    check("adv_value", 32'(out_value), 32'd0);
    check("adv_count", 32'(count), 32'd0);

    // Fill and overflow.
    for (int i = 1; i <= 4; i++) push_word(WIDTH'(i));
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(load_ready), 32'd0);
    push_word(16'hBABA);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain_%0d", i), 32'(out_value), 32'(i));
      pop_word();
    end
    check("drain_count", 32'(count), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    do_flush();
    check("flush_clr_ovf", 32'(overflow), 32'd0);

    // Wrap-around: hold 3 entries, 6 edges of push+pop.
    push_word(16'h000A);
    push_word(16'h000B);
    push_word(16'h000C);
    exp_q = '{16'h000A, 16'h000B, 16'h000C};
    for (int i = 0; i < 6; i++) begin
      check($sformatf("wrap_head_%0d", i), 32'(out_value), 32'(exp_q[0]));
      ir_load    = 1'b1;
      in_value   = WIDTH'(16'h0010 + i);
      ir_advance = 1'b1;
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(WIDTH'(16'h0010 + i));
      check($sformatf("wrap_count_%0d", i), 32'(count), 32'd3);
    end
    ir_load    = 1'b0;
    ir_advance = 1'b0;
    push_word(16'h0016);
    check("wrap_full", 32'(count), 32'd4);
    // Full: push refused even with a simultaneous pop.
    ir_load    = 1'b1;
    in_value   = 16'h0017;
    ir_advance = 1'b1;
    step();
    ir_load    = 1'b0;
    ir_advance = 1'b0;
    check("full_pp_count", 32'(count), 32'd3);
    check("full_pp_ovf", 32'(overflow), 32'd1);
    check("full_pp_head", 32'(out_value), 32'h0014);
    pop_word();
    check("wrap_tail_15", 32'(out_value), 32'h0015);
    pop_word();
    check("wrap_tail_16", 32'(out_value), 32'h0016);
    pop_word();
    check("wrap_empty", 32'(count), 32'd0);
    do_flush();

    // Empty pop is ignored.
    pop_word();
    check("epop_count", 32'(count), 32'd0);
    check("epop_ovf", 32'(overflow), 32'd0);
    check("epop_valid", 32'(out_valid), 32'd0);
    push_word(16'h1234);
    check("epop_push_value", 32'(out_value), 32'h1234);
    check("epop_push_count", 32'(count), 32'd1);
    pop_word();

    // Flush priority with 2 entries queued and overflow set.
    for (int i = 0; i < 4; i++) push_word(WIDTH'(16'h0040 + i));
    push_word(16'hDEAD);
    pop_word();
    pop_word();
    check("pre_flush_count", 32'(count), 32'd2);
    check("pre_flush_ovf", 32'(overflow), 32'd1);
    flush      = 1'b1;
    ir_load    = 1'b1;
    in_value   = 16'h5555;
    ir_advance = 1'b1;
    step();
    flush      = 1'b0;
    ir_load    = 1'b0;
    ir_advance = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_value", 32'(out_value), 32'd0);
    check("flush_ovf", 32'(overflow), 32'd0);
    check("flush_ready", 32'(load_ready), 32'd1);

    // Asynchronous reset with 3 entries queued.
    push_word(16'h0071);
    push_word(16'h0072);
    push_word(16'h0073);
    check("pre_rst_count", 32'(count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_value", 32'(out_value), 32'd0);
    check("arst_ready", 32'(load_ready), 32'd1);
    #1 rst_n = 1'b1;
    push_word(16'hFDFD);
    check("post_rst_value", 32'(out_value), 32'hFDFD);
    check("post_rst_count", 32'(count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
